sobel_frame_ctrl: RTL and testbench
===================================

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter SIZE_X, default 800, image width in pixels (>= 4).
REQ-002 Parameter SIZE_Y, default 600, image height in lines (>= 3).
REQ-003 clock  in  1  master clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  frame start request; sampled only in IDLE.
REQ-006 in_valid  in  1  upstream pixel available.
REQ-007 in_ready  out  1  pixel accepted this cycle when in_valid && in_ready.
REQ-008 sobel_en  out  1  drives the filter's control (window shift and pout capture enable).
REQ-009 pin_zero  out  1  selects 0 instead of upstream pixel on the filter's pin mux (flush).
REQ-010 out_valid  out  1  filter pout holds a new in-frame result this cycle.
REQ-011 out_x  out  10  column of the result on pout; out_y  out  10  row of the result.
REQ-012 out_border  out  1  result column is 0 or SIZE_X-1, or row is 0 or SIZE_Y-1 (window not fully in frame).
REQ-013 busy  out  1  high in RUN and FLUSH; frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-014 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on acceptance of pixel index N-1 (N=SIZE_X*SIZE_Y); FLUSH->DONE after SIZE_X+4 cycles; DONE->IDLE after exactly 1 cycle.
REQ-015 start outside IDLE is ignored; start in IDLE clears pixel counter k, column/row counters, flush counter, and delay line.
REQ-016 RUN: in_ready=1, sobel_en=in_valid, pin_zero=0; k increments per accepted pixel; no stall of window when in_valid=0.
REQ-017 FLUSH: in_ready=0, sobel_en=1 every cycle, pin_zero=1; each enable advances k past N-1.
REQ-018 IDLE, DONE: in_ready=0, sobel_en=0, pin_zero=0.
REQ-019 Window tag: on each enable edge with pixel index k, tag.valid = (k >= SIZE_X+1) && (k-(SIZE_X+1) < N); tag.x,y = column/row of center index c = k-(SIZE_X+1); tag.toggle inverts.
REQ-020 Tag feeds a 3-stage delay line shifted every clock unconditionally (matches window->H->H1->pout pipeline).
REQ-021 out_valid registered: 1 in cycle after edge e iff sobel_en at e && tap3.valid && tap3.toggle != emitted_toggle; emitted_toggle <= tap3.toggle when out_valid set; out_x/out_y/out_border from tap3.
REQ-022 Each center c in 0..N-1 yields exactly one out_valid, in increasing c order, for gapless and gapped input.
REQ-023 Gapless frame: center c output out_valid at cycle (accept cycle of pixel c+SIZE_X+1) + 4.
REQ-024 Column/row counters wrap: x SIZE_X-1 -> 0 increments y; y not incremented past SIZE_Y-1.
REQ-025 frame_done high only in DONE; busy low in DONE.
REQ-026 Counter widths sized for N+SIZE_X+4 without overflow; no arithmetic wrap during FLUSH.

Reset
REQ-027 On reset: state IDLE; in_ready, sobel_en, pin_zero, out_valid, out_border, busy, frame_done = 0; out_x, out_y = 0; counters, delay line, toggles = 0.
REQ-028 Reset mid-RUN or mid-FLUSH aborts the frame next cycle with no frame_done; filter window contents are not cleared (next frame's first valid output is c=0, a border result).
REQ-029 Reset dominates start in the same cycle.

Verification (SIZE_X=8, SIZE_Y=6, N=48)
REQ-030 Reset, then start with gapless in_valid -> 48 accepts, FLUSH 12 cycles, 48 out_valid pulses c=0..47, frame_done one pulse.
REQ-031 Gapless frame -> first out_valid (0,0) border=1 at accept cycle of pixel 9 plus 4; (1,1) border=0; (7,5) border=1 last.
REQ-032 in_valid toggling 1/0 every cycle -> still 48 results in order, none duplicated, out_x/out_y match golden.
REQ-033 start pulsed during RUN and FLUSH -> ignored; pixel count and frame_done timing unchanged.
REQ-034 reset asserted at pixel 20 -> outputs zero next cycle, no frame_done; new start runs a full correct frame.
REQ-035 Back-to-back frames with start in the cycle after frame_done -> second frame identical result sequence.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame controller: sequences one frame of pixels through a 3x3 Sobel
//   filter, flushes the window with zeros, and tags each filter result with its
//   centre column/row. Results appear 4 cycles after the pixel that completes
//   their window when input is gapless. in_ready is high for the whole of RUN,
//   and the filter window does not stall when in_valid is low.
// Ports: clock/reset (sync, active-high); start (frame request, honoured in IDLE);
//   in_valid/in_ready (pixel handshake); sobel_en/pin_zero (filter control);
//   out_valid/out_x/out_y/out_border (result tag); busy/frame_done (status).
module sobel_frame_ctrl #(
   parameter int SIZE_X = 800,
   parameter int SIZE_Y = 600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       sobel_en,
   output logic       pin_zero,
   output logic       out_valid,
   output logic [9:0] out_x,
   output logic [9:0] out_y,
   output logic       out_border,
   output logic       busy,
   output logic       frame_done
);

   localparam int N  = SIZE_X * SIZE_Y;
   // k runs on through the flush to N+SIZE_X+4, fcnt to SIZE_X+4
   localparam int KW = $clog2(N + SIZE_X + 5);
   localparam int FW = $clog2(SIZE_X + 5);

   localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
   localparam logic [KW-1:0] K_FIRST = KW'(SIZE_X + 1);
   localparam logic [KW-1:0] K_END   = KW'(N + SIZE_X + 1);
   localparam logic [FW-1:0] F_LAST  = FW'(SIZE_X + 3);
   localparam logic [9:0]    X_LAST  = 10'(SIZE_X - 1);
   localparam logic [9:0]    Y_LAST  = 10'(SIZE_Y - 1);

   typedef struct packed {
      logic       valid;
      logic [9:0] x;
      logic [9:0] y;
      logic       border;
      logic       toggle;
   } tag_t;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t        state, state_nxt;
   logic [KW-1:0] k;
   logic [FW-1:0] fcnt;
   logic [9:0]    cx, cy;
   tag_t          tap1, tap2, tap3;
   tag_t          tag_new;
   logic          emitted;
   logic          clear;
   logic          win_valid;

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      sobel_en   = 1'b0;
      pin_zero   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            sobel_en = in_valid;
            busy     = 1'b1;
            if (in_valid && (k == K_LAST)) state_nxt = FLUSH;
         end
         FLUSH: begin
            sobel_en = 1'b1;
            pin_zero = 1'b1;
            busy     = 1'b1;
            if (fcnt == F_LAST) state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clear     = (state == IDLE) && start;
   // window is centred on an in-frame pixel once SIZE_X+1 pixels have passed
   assign win_valid = (k >= K_FIRST) && (k < K_END);

   always_comb begin
      tag_new.valid  = win_valid;
      tag_new.x      = cx;
      tag_new.y      = cy;
      tag_new.border = (cx == 10'd0) || (cx == X_LAST) ||
                       (cy == 10'd0) || (cy == Y_LAST);
      // stage 1 holds the current window tag, so its toggle is the reference
      tag_new.toggle = ~tap1.toggle;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         k          <= '0;
         fcnt       <= '0;
         cx         <= '0;
         cy         <= '0;
         tap1       <= '0;
         tap2       <= '0;
         tap3       <= '0;
         emitted    <= 1'b0;
         out_valid  <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         out_border <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clear) begin
            k         <= '0;
            fcnt      <= '0;
            cx        <= '0;
            cy        <= '0;
            tap1      <= '0;
            tap2      <= '0;
            tap3      <= '0;
            emitted   <= 1'b0;
            out_valid <= 1'b0;
         end else begin
            if (sobel_en) begin
               k <= k + KW'(1);
               if (win_valid) begin
                  if (cx == X_LAST) begin
                     cx <= '0;
                     if (cy != Y_LAST) cy <= cy + 10'd1;
                  end else begin
                     cx <= cx + 10'd1;
                  end
               end
            end
            if (state == FLUSH) fcnt <= fcnt + FW'(1);

            // stage 1 tracks the window (reloads itself while the window is
            // still); later stages follow the filter's free-running H/H1 regs
            tap1 <= sobel_en ? tag_new : tap1;
            tap2 <= tap1;
            tap3 <= tap2;

            // pout only captures on enable; a toggle change marks a tag not yet
            // consumed, invalid tags are consumed silently
            out_valid <= 1'b0;
            if (sobel_en && (tap3.toggle != emitted)) begin
               emitted <= tap3.toggle;
               if (tap3.valid) begin
                  out_valid  <= 1'b1;
                  out_x      <= tap3.x;
                  out_y      <= tap3.y;
                  out_border <= tap3.border;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

   localparam int SX = 8;
   localparam int SY = 6;
   localparam int N  = SX * SY;
   localparam int NE = N + SX + 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic       sobel_en;
   logic       pin_zero;
   logic       out_valid;
   logic [9:0] out_x;
   logic [9:0] out_y;
   logic       out_border;
   logic       busy;
   logic       frame_done;

   always #5 clock = ~clock;

   sobel_frame_ctrl #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sobel_en   (sobel_en),
      .pin_zero   (pin_zero),
      .out_valid  (out_valid),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_border (out_border),
      .busy       (busy),
      .frame_done (frame_done)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference: frame phase from accepted-pixel and flush-cycle counts,
   // expected results as the raster sequence c = 0..N-1
   typedef enum int {P_IDLE, P_RUN, P_FLUSH, P_DONE} phase_t;
   phase_t m_phase   = P_IDLE;
   int     m_acc     = 0;
   int     m_fl      = 0;
   int     m_k       = 0;
   int     m_c       = 0;
   int     cyc       = 0;
   int     en_cycle[NE];
   bit     m_known   = 0;
   bit     chk_zero  = 0;
   bit     m_gapless = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the reference on the edge.
   task automatic cyc_step();
      bit en;
      #1;
      if (m_known) begin
         check("in_ready",   in_ready,   m_phase == P_RUN);
         check("sobel_en",   sobel_en,   (m_phase == P_RUN && in_valid) || m_phase == P_FLUSH);
         check("pin_zero",   pin_zero,   m_phase == P_FLUSH);
         check("busy",       busy,       m_phase == P_RUN || m_phase == P_FLUSH);
         check("frame_done", frame_done, m_phase == P_DONE);
         if (chk_zero) begin
            check("rst_out_valid",  out_valid,  0);
            check("rst_out_x",      out_x,      0);
            check("rst_out_y",      out_y,      0);
            check("rst_out_border", out_border, 0);
            chk_zero = 0;
         end
         if (out_valid === 1'b1) begin
            check("extra_result", m_c < N, 1);
            check("out_x", out_x, m_c % SX);
            check("out_y", out_y, m_c / SX);
            check("out_border", out_border,
                  (m_c % SX == 0) || (m_c % SX == SX - 1) ||
                  (m_c / SX == 0) || (m_c / SX == SY - 1));
            if (m_gapless && (m_c + SX + 1 < m_k))
               check("out_cycle", cyc, en_cycle[m_c + SX + 1] + 4);
            m_c++;
         end
         if (m_phase == P_DONE) check("result_count", m_c, N);
      end
      @(posedge clock);
      en = (m_phase == P_RUN && in_valid) || m_phase == P_FLUSH;
      if (reset) begin
         m_phase  = P_IDLE;
         m_known  = 1;
         chk_zero = 1;
         m_acc    = 0;
         m_k      = 0;
         m_c      = 0;
      end else begin
         if (en && m_k < NE) begin
            en_cycle[m_k] = cyc;
            m_k++;
         end
         case (m_phase)
            P_IDLE:  if (start) begin
                        m_phase = P_RUN;
                        m_acc = 0; m_fl = 0; m_k = 0; m_c = 0;
                     end
            P_RUN:   if (in_valid) begin
                        m_acc++;
                        if (m_acc == N) begin m_phase = P_FLUSH; m_fl = 0; end
                     end
            P_FLUSH: begin
                        m_fl++;
                        if (m_fl == SX + 4) m_phase = P_DONE;
                     end
            default: m_phase = P_IDLE;
         endcase
      end
      cyc++;
      @(negedge clock);
   endtask

   // alt: in_valid toggles every cycle; noise: random start pulses while busy;
   // abort_at >= 0: reset when that many pixels have been accepted
   task automatic run_frame(input bit alt, input bit noise, input int abort_at);
      bit ph;
      int guard;
      m_gapless = !alt;
      ph        = 1'($urandom_range(0, 1));
      start     = 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      cyc_step();
      start = 1'b0;
      guard = 0;
      while (m_phase != P_IDLE && guard < 5000) begin
         in_valid = alt ? ph : 1'b1;
         ph       = ~ph;
         start    = noise && ($urandom_range(0, 3) == 0);
         reset    = (abort_at >= 0) && (m_phase == P_RUN) && (m_acc == abort_at);
         cyc_step();
         reset = 1'b0;
         guard++;
      end
      check("frame_timeout", guard < 5000, 1);
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      // reset held with start high: reset must win
      reset    = 1'b1;
      start    = 1'b1;
      in_valid = 1'b1;
      @(negedge clock);
      repeat (3) cyc_step();
      reset = 1'b0;
      start = 1'b0;
      // idle with pixels offered: nothing accepted
      repeat (3) cyc_step();
      in_valid = 1'b0;

      run_frame(1'b0, 1'b0, -1);          // gapless, exact timing
      repeat (2) cyc_step();
      run_frame(1'b1, 1'b0, -1);          // in_valid toggling
      repeat (2) cyc_step();
      run_frame(1'b0, 1'b1, -1);          // start noise, gapless timing
      run_frame(1'b1, 1'b1, -1);          // start noise, toggling
      repeat (2) cyc_step();
      run_frame(1'b0, 1'b0, 20);          // abort at pixel 20
      run_frame(1'b0, 1'b0, -1);          // full frame after abort
      run_frame(1'b0, 1'b0, -1);          // back-to-back frame
      repeat (4) cyc_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
